// File: rtl/fpa_sched_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
package fpa_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2
   } sched_state_e;

   localparam logic [2:0] FPA_PHASE_CHECK   = 3'd4;
   localparam int         FPA_PASSES_PER_OP = 2;
   localparam logic [3:0] STATUS_TIMEOUT    = 4'hF;

endpackage

// File: rtl/fpa_add_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request after last_grant_i, wrapping modulo N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] last_grant_i,
   output logic [N_REQ-1:0]         grant_o,
   output logic [$clog2(N_REQ)-1:0] grant_idx_o,
   output logic                     any_o
);
   localparam int IW = $clog2(N_REQ);

   logic [IW:0] sum_s;
   logic [IW:0] cand_s;

   // Walk from the lowest priority to the highest so the nearest request wins last.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      sum_s       = '0;
      cand_s      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         sum_s  = {1'b0, last_grant_i} + (IW+1)'(k);
         cand_s = (sum_s >= (IW+1)'(N_REQ)) ? (sum_s - (IW+1)'(N_REQ)) : sum_s;
         if (req_i[cand_s[IW-1:0]]) begin
            grant_o                   = '0;
            grant_o[cand_s[IW-1:0]]   = 1'b1;
            grant_idx_o               = cand_s[IW-1:0];
            any_o                     = 1'b1;
         end else begin
         end
      end
   end

endmodule

// File: rtl/fpa_add_scheduler.sv
// Round-robin sharing of one two-pass floating-point adder among N_REQ requesters.
// Define FPA_SCHED_TIMEOUT_EN to abort a RUN state lasting TIMEOUT_CYC cycles.
module fpa_add_scheduler
   import fpa_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 128
) (
   input  logic                  clock_100kHz,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_op_a,
   input  logic [32*N_REQ-1:0]   req_op_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [31:0]           rsp_data,
   output logic [3:0]            rsp_status,
   output logic                  busy,
   output logic                  fpa_rst_n,
   output logic [31:0]           fpa_op_a,
   output logic [31:0]           fpa_op_b,
   input  logic [2:0]            fpa_qual_lugar,
   input  logic [31:0]           fpa_data,
   input  logic [3:0]            fpa_status
);
   localparam int IW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_chk
      $error("fpa_add_scheduler: N_REQ or TIMEOUT_CYC out of range");
   end

   sched_state_e     state_q, state_d;
   logic [IW-1:0]    last_grant_q, last_grant_d;
   logic [IW-1:0]    winner_q, winner_d;
   logic [IW-1:0]    grant_idx_s;
   logic [N_REQ-1:0] grant_s;
   logic             any_s;
   logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
   logic [31:0]      sel_a_s, sel_b_s;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [3:0]       rsp_status_q, rsp_status_d;
   logic [1:0]       events_q, events_d;
   logic             prev_chk_q, prev_chk_d;
   logic             fpa_rst_n_q, fpa_rst_n_d;
   logic             chk_event_s, last_pass_s;
`ifdef FPA_SCHED_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0]       timer_q, timer_d;
`endif

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant_s),
      .grant_idx_o  (grant_idx_s),
      .any_o        (any_s)
   );

   always_comb begin
      sel_a_s = '0;
      sel_b_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_a_s = sel_a_s | ({32{grant_s[i]}} & req_op_a[32*i +: 32]);
         sel_b_s = sel_b_s | ({32{grant_s[i]}} & req_op_b[32*i +: 32]);
      end
   end

   // A check event is a fresh rise to the status phase; the flag reads "was 4" outside RUN.
   assign chk_event_s = (state_q == ST_RUN) && (fpa_qual_lugar == FPA_PHASE_CHECK) && !prev_chk_q;
   assign last_pass_s = (events_q == 2'(FPA_PASSES_PER_OP - 1));

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      winner_d     = winner_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_data_d   = rsp_data_q;
      rsp_status_d = rsp_status_q;
      events_d     = events_q;
      fpa_rst_n_d  = 1'b0;
      prev_chk_d   = (state_q == ST_RUN) ? (fpa_qual_lugar == FPA_PHASE_CHECK) : 1'b1;
`ifdef FPA_SCHED_TIMEOUT_EN
      timer_d      = timer_q;
`endif
      case (state_q)
         ST_IDLE: begin
            events_d = 2'd0;
`ifdef FPA_SCHED_TIMEOUT_EN
            timer_d  = 8'd0;
`endif
            if (any_s) begin
               state_d      = ST_RUN;
               winner_d     = grant_idx_s;
               last_grant_d = grant_idx_s;
               op_a_d       = sel_a_s;
               op_b_d       = sel_b_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            fpa_rst_n_d = 1'b1;
`ifdef FPA_SCHED_TIMEOUT_EN
            timer_d     = timer_q + 8'd1;
`endif
            if (chk_event_s && last_pass_s) begin
               rsp_data_d   = fpa_data;
               rsp_status_d = fpa_status;
               state_d      = ST_RESP;
`ifdef FPA_SCHED_TIMEOUT_EN
            end else if (timer_q == TO_LAST) begin
               rsp_data_d   = 32'd0;
               rsp_status_d = STATUS_TIMEOUT;
               state_d      = ST_RESP;
`endif
            end else if (chk_event_s) begin
               events_d = events_q + 2'd1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_100kHz or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IW'(N_REQ - 1);
         winner_q     <= '0;
         op_a_q       <= 32'd0;
         op_b_q       <= 32'd0;
         rsp_data_q   <= 32'd0;
         rsp_status_q <= 4'd0;
         events_q     <= 2'd0;
         prev_chk_q   <= 1'b1;
         fpa_rst_n_q  <= 1'b0;
`ifdef FPA_SCHED_TIMEOUT_EN
         timer_q      <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         winner_q     <= winner_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_data_q   <= rsp_data_d;
         rsp_status_q <= rsp_status_d;
         events_q     <= events_d;
         prev_chk_q   <= prev_chk_d;
         fpa_rst_n_q  <= fpa_rst_n_d;
`ifdef FPA_SCHED_TIMEOUT_EN
         timer_q      <= timer_d;
`endif
      end
   end

   // Grants are gated by reset so req_ready reads zero while reset is held.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if ((state_q == ST_IDLE) && reset) begin
         req_ready = grant_s;
      end else begin
         req_ready = '0;
      end
      if (state_q == ST_RESP) begin
         rsp_valid[winner_q] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign fpa_rst_n  = fpa_rst_n_q;
   assign fpa_op_a   = op_a_q;
   assign fpa_op_b   = op_b_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_status = rsp_status_q;

endmodule

// File: doc/fpa_add_scheduler.md
# fpa_add_scheduler

Round-robin scheduler that shares one free-running floating-point adder (32-bit format: sign [31], 6-bit exponent [30:25], 25-bit mantissa [24:0]) among N_REQ requesters. It latches the winning requester's operands and drives them to the adder. It resets the adder so every pass starts from a known state, then tracks the adder's phase output and returns the valid result and status to the requester.

## Interface
- N_REQ, 4: number of requesters (2..8)
- TIMEOUT_CYC, 128: RUN-state cycle limit before abort (only with FPA_SCHED_TIMEOUT_EN)

Ports:
- clock_100kHz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  request pending, held until granted
- req_op_a  in  32*N_REQ  operand A per requester, slice i = [32*i+31:32*i]
- req_op_b  in  32*N_REQ  operand B per requester
- req_ready  out  N_REQ  one-hot, 1-cycle grant; operands sampled on this edge
- rsp_valid  out  N_REQ  one-hot, 1-cycle result strobe to granted requester
- rsp_data  out  32  result word, valid while rsp_valid != 0
- rsp_status  out  4  adder status (0 exact, 1 overflow, 2 underflow, 3 inexact), 4'hF timeout
- busy  out  1  high from grant edge until the RESP cycle ends
- fpa_rst_n  out  1  active-low reset to the adder
- fpa_op_a / fpa_op_b  out  32  operands to the adder, stable for the whole RUN state
- fpa_qual_lugar  in  3  adder phase code (4 = status valid)
- fpa_data  in  32  adder result
- fpa_status  in  4  adder status

## Operation
- States: IDLE, RUN, RESP.
- IDLE:
  - fpa_rst_n=0 (adder held in reset).
  - If any req_valid, the round-robin winner is the first set bit searching from last_grant+1 modulo N_REQ.
  - req_ready[winner]=1 combinationally.
  - Clock edge: latch fpa_op_a/b from the winner's slice, store the winner index, last_grant<=winner, go to RUN.
- RUN:
  - fpa_rst_n=1.
  - Check event: fpa_qual_lugar==4 while the previous-cycle value !=4. The previous-value flag is forced to "was 4" outside RUN, so a stale code held through adder reset never counts.
  - The adder ignores operands on its first pass after reset, so the first check event is discarded. On the second event, capture fpa_data/fpa_status into rsp_data/rsp_status and go to RESP.
- RESP:
  - rsp_valid[winner]=1 for exactly one cycle; no back-pressure.
  - fpa_rst_n<=0, go to IDLE.
- Requests that arrive or are held during RUN or RESP wait; grants occur only in IDLE.
- Simultaneous requests: exactly one grant per transaction. A requester that just won has lowest priority next time.
- rsp_data/rsp_status hold their last values until the next capture.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_status=0, busy=0, fpa_rst_n=0, fpa_op_a/b=0, last_grant=N_REQ-1 (requester 0 wins first), state IDLE.
- Reset asserted mid-transaction: in-flight request is abandoned with no rsp_valid, and the adder is held in reset.
- Grant at edge T. fpa_rst_n rises at T+1.
- Adder pass is at least 6 cycles (POS_OPERATION loop is data-dependent). Two passes give grant-to-rsp_valid latency of at least 13 cycles.
- Back-to-back: the next grant is possible in the IDLE cycle immediately after RESP.

## Configuration
- FPA_SCHED_TIMEOUT_EN defined:
  - 8-bit counter clears on entering RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYC before the second check event: rsp_data=0, rsp_status=4'hF, go to RESP.
- FPA_SCHED_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; TIMEOUT_CYC is ignored.

## Structure
- Package fpa_sched_pkg holds:
  - state enum
  - FPA_PHASE_CHECK=3'd4
  - FPA_PASSES_PER_OP=2
  - STATUS_TIMEOUT=4'hF
- Sub-module rr_arbiter (N_REQ parameter; inputs req and last_grant; outputs one-hot grant and index) contains the combinational priority search. The scheduler owns the last_grant register.

## Test plan
- Real adder, requester 0 submits A=B=0x40000000 -> one req_ready[0] pulse, fpa_rst_n high for two passes, rsp_valid[0] with rsp_data/rsp_status matching the adder model. Data must not come from the first pass.
- Requesters 0..3 all held valid -> grants in order 0,1,2,3,0; each rsp_valid goes only to its own requester.
- Stub adder holds fpa_qual_lugar=4 through reset, then produces check events with data 0x11111111, then 0x22222222 -> rsp_data=0x22222222.
- Stub adder never shows phase 4, macro defined, TIMEOUT_CYC=20 -> rsp_valid 20 cycles after RUN entry, rsp_status=4'hF, rsp_data=0. Macro undefined -> no response, busy stays 1.
- reset pulled low mid-RUN -> all outputs at reset values immediately, no rsp_valid. After release, a new request completes normally.
- req_valid[2] asserted during RESP of requester 1 -> no grant until the following IDLE cycle, then req_ready[2].
